// File: rtl/mem2axi_if.sv
// AXI4 bus bundle used by the mem2axi bridge; master modport drives requests, slave drives responses.
interface mem2axi_if #(
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [5:0]                  aw_atop;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/mem2axi.sv
// Memory-port (req/gnt/rvalid) to AXI4 single-beat master bridge, one transaction in flight.
// Define MEM2AXI_POSTED_WRITE_EN to complete writes before B; B errors then set sticky write_err_o.
module mem2axi #(
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  output logic                        gnt_o,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  output logic                        write_err_o,
  mem2axi_if.master                   master
);

  localparam int unsigned StrbWidth = AXI_DATA_WIDTH / 8;
  localparam int unsigned OffWidth  = $clog2(StrbWidth);
  localparam logic [AXI_ADDR_WIDTH-1:0] AlignMask = {AXI_ADDR_WIDTH{1'b1}} << OffWidth;
  localparam logic [2:0] AxSize = 3'(OffWidth);

  typedef enum logic [2:0] {StIdle, StWrite, StWaitB, StRead, StWaitR} state_e;

  state_e                      state_q;
  logic                        aw_valid_q, w_valid_q, ar_valid_q, b_ready_q, r_ready_q;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [StrbWidth-1:0]        be_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic                        rvalid_q, err_q, write_err_q;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q;
  logic                        aw_done, w_done;

  // A channel counts as done if already handshaken or handshaking this cycle.
  assign aw_done = ~aw_valid_q | master.aw_ready;
  assign w_done  = ~w_valid_q | master.w_ready;

  assign gnt_o       = req_i & (state_q == StIdle);
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign write_err_o = write_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      b_ready_q   <= 1'b0;
      r_ready_q   <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      write_err_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_i) begin
            addr_q  <= addr_i & AlignMask;
            be_q    <= be_i;
            wdata_q <= wdata_i;
            if (we_i) begin
              state_q    <= StWrite;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
            end else begin
              state_q    <= StRead;
              ar_valid_q <= 1'b1;
            end
          end
        end
        StWrite: begin
          if (master.aw_ready) aw_valid_q <= 1'b0;
          if (master.w_ready) w_valid_q <= 1'b0;
          if (aw_done && w_done) begin
            state_q   <= StWaitB;
            b_ready_q <= 1'b1;
`ifdef MEM2AXI_POSTED_WRITE_EN
            rvalid_q  <= 1'b1;
            err_q     <= 1'b0;
`endif
          end
        end
        StWaitB: begin
          if (master.b_valid) begin
            state_q   <= StIdle;
            b_ready_q <= 1'b0;
`ifdef MEM2AXI_POSTED_WRITE_EN
            if (master.b_resp[1]) write_err_q <= 1'b1;
`else
            rvalid_q  <= 1'b1;
            err_q     <= master.b_resp[1];
`endif
          end
        end
        StRead: begin
          if (master.ar_ready) begin
            state_q    <= StWaitR;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
          end
        end
        StWaitR: begin
          if (master.r_valid) begin
            state_q   <= StIdle;
            r_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= master.r_data;
            err_q     <= master.r_resp[1];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
  assign master.aw_addr   = addr_q;
  assign master.aw_len    = 8'd0;
  assign master.aw_size   = AxSize;
  assign master.aw_burst  = 2'b01;
  assign master.aw_lock   = 1'b0;
  assign master.aw_cache  = 4'd0;
  assign master.aw_prot   = 3'd0;
  assign master.aw_qos    = 4'd0;
  assign master.aw_region = 4'd0;
  assign master.aw_atop   = 6'd0;
  assign master.aw_user   = '0;
  assign master.aw_valid  = aw_valid_q;

  assign master.w_data    = wdata_q;
  assign master.w_strb    = be_q;
  assign master.w_last    = 1'b1;
  assign master.w_user    = '0;
  assign master.w_valid   = w_valid_q;

  assign master.b_ready   = b_ready_q;

  assign master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
  assign master.ar_addr   = addr_q;
  assign master.ar_len    = 8'd0;
  assign master.ar_size   = AxSize;
  assign master.ar_burst  = 2'b01;
  assign master.ar_lock   = 1'b0;
  assign master.ar_cache  = 4'd0;
  assign master.ar_prot   = 3'd0;
  assign master.ar_qos    = 4'd0;
  assign master.ar_region = 4'd0;
  assign master.ar_user   = '0;
  assign master.ar_valid  = ar_valid_q;

  assign master.r_ready   = r_ready_q;

  // Response sideband that a single-beat, single-id master has no use for.
  logic unused_axi;
  assign unused_axi = ^{master.b_id, master.b_user, master.b_resp[0], master.r_id,
                        master.r_last, master.r_user, master.r_resp[0]};

endmodule

// File: tb/tb_mem2axi.sv
// Self-checking bench for mem2axi: scripted requester, delay-programmable AXI slave, scoreboard.
module tb_mem2axi;
  localparam int unsigned IdW = 10, AddrW = 64, DataW = 64, UserW = 10;
`ifdef MEM2AXI_POSTED_WRITE_EN
  localparam bit Posted = 1'b1;
`else
  localparam bit Posted = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_i;
  logic             req, we, gnt, rvalid, err, write_err;
  logic [AddrW-1:0] addr;
  logic [7:0]       be;
  logic [DataW-1:0] wdata, rdata;

  always #5 clk = ~clk;

  mem2axi_if #(.AXI_ID_WIDTH(IdW), .AXI_ADDR_WIDTH(AddrW), .AXI_DATA_WIDTH(DataW),
               .AXI_USER_WIDTH(UserW)) bus ();

  mem2axi #(.AXI_ID_WIDTH(IdW), .AXI_ADDR_WIDTH(AddrW), .AXI_DATA_WIDTH(DataW),
            .AXI_USER_WIDTH(UserW), .AXI_ID(0)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .write_err_o(write_err), .master(bus)
  );

  typedef struct {logic [63:0] rdata; logic err; int lat; int gcyc;} sb_t;
  typedef struct {logic we; logic [63:0] addr; logic [7:0] be; logic [63:0] wdata;} ax_t;

  sb_t sb_q[$];
  ax_t ax_q[$];
  ax_t w_q[$];

  int checks = 0, failures = 0, cyc = 0;
  int ar_dly, aw_dly, w_dly, b_dly, r_dly, aw_hs_cyc, w_hs_cyc;
  logic [1:0]  r_resp_cfg, b_resp_cfg;
  logic [63:0] rd_data, last_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_dly(input int ar, input int aw, input int w, input int b, input int r);
    ar_dly = ar; aw_dly = aw; w_dly = w; b_dly = b; r_dly = r;
  endtask

  // Called on a falling edge; returns on the falling edge after the grant cycle.
  task automatic issue(input logic w, input logic [63:0] a, input logic [7:0] b,
                       input logic [63:0] d, input logic [63:0] rdv, input logic [1:0] resp,
                       input int lat, output int waited, output int gc);
    sb_t e;
    ax_t x;
    waited = 0;
    gc = cyc;
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    #1;
    while (!gnt && waited < 60) begin
      @(negedge clk);
      waited++;
      #1;
    end
    if (!gnt) begin
      check("gnt_timeout", 64'd0, 64'd1);
      req = 1'b0;
      return;
    end
    gc = cyc;
    x.we = w; x.addr = a & ~64'h7; x.be = b; x.wdata = d;
    ax_q.push_back(x);
    if (w) begin
      w_q.push_back(x);
      b_resp_cfg = resp;
      e.rdata = last_rdata;
      e.err = Posted ? 1'b0 : resp[1];
    end else begin
      r_resp_cfg = resp;
      rd_data = rdv;
      e.rdata = rdv;
      e.err = resp[1];
      last_rdata = rdv;
    end
    e.lat = lat;
    e.gcyc = gc;
    sb_q.push_back(e);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", 64'd0, 64'd1);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_rvalid(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rvalid && n < budget);
    if (!rvalid) check("rvalid_timeout", 64'd0, 64'd1);
  endtask

  always @(negedge clk) begin : monitor
    sb_t e;
    if (!rst_i && rvalid) begin
      if (sb_q.size() == 0) check("spurious_rvalid", 64'd1, 64'd0);
      else begin
        e = sb_q.pop_front();
        check("rdata", rdata, e.rdata);
        check("err", {63'd0, err}, {63'd0, e.err});
        if (e.lat >= 0) check("latency", 64'(cyc - e.gcyc), 64'(e.lat));
      end
    end
  end

  // AXI slave: readies/valids change on falling edges, each channel with its own delay.
  initial begin : slave
    int ar_cnt, aw_cnt, w_cnt, b_cnt, r_cnt;
    bit r_pend, b_pend, aw_seen, w_seen, r_hs, b_hs;
    ax_t a;
    bus.aw_ready = 0; bus.w_ready = 0; bus.ar_ready = 0; bus.b_valid = 0; bus.r_valid = 0;
    bus.b_id = '0; bus.b_resp = 0; bus.b_user = '0; bus.r_id = '0; bus.r_data = '0;
    bus.r_resp = 0; bus.r_last = 1'b1; bus.r_user = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        bus.aw_ready = 0; bus.w_ready = 0; bus.ar_ready = 0; bus.b_valid = 0; bus.r_valid = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
        r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0; r_hs = 0; b_hs = 0;
        continue;
      end
      if (r_hs) begin bus.r_valid = 0; r_hs = 0; end
      if (r_pend && !bus.r_valid) begin
        if (r_cnt >= r_dly) begin
          bus.r_valid = 1; bus.r_data = rd_data; bus.r_resp = r_resp_cfg; r_pend = 0; r_cnt = 0;
        end else r_cnt++;
      end
      if (bus.r_valid) r_hs = bus.r_ready;
      if (b_hs) begin bus.b_valid = 0; b_hs = 0; end
      if (b_pend && !bus.b_valid) begin
        if (b_cnt >= b_dly) begin
          bus.b_valid = 1; bus.b_resp = b_resp_cfg; b_pend = 0; b_cnt = 0;
        end else b_cnt++;
      end
      if (bus.b_valid) b_hs = bus.b_ready;
      if (!bus.ar_valid) begin bus.ar_ready = 0; ar_cnt = 0; end
      else if (ar_cnt >= ar_dly) begin
        bus.ar_ready = 1; ar_cnt = 0; r_pend = 1; r_cnt = 0;
        if (ax_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
        else begin
          a = ax_q.pop_front();
          check("ar_is_read", {63'd0, a.we}, 64'd0);
          check("ar_addr", bus.ar_addr, a.addr);
          check("ar_len_size_burst", {bus.ar_len, bus.ar_size, bus.ar_burst}, {8'd0, 3'd3, 2'b01});
          check("ar_fixed", {bus.ar_id, bus.ar_lock, bus.ar_cache, bus.ar_prot, bus.ar_qos,
                             bus.ar_region, bus.ar_user}, 64'd0);
        end
      end else begin bus.ar_ready = 0; ar_cnt++; end
      if (!bus.aw_valid) begin bus.aw_ready = 0; aw_cnt = 0; end
      else if (aw_cnt >= aw_dly) begin
        bus.aw_ready = 1; aw_cnt = 0; aw_seen = 1; aw_hs_cyc = cyc;
        if (ax_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
        else begin
          a = ax_q.pop_front();
          check("aw_is_write", {63'd0, a.we}, 64'd1);
          check("aw_addr", bus.aw_addr, a.addr);
          check("aw_len_size_burst", {bus.aw_len, bus.aw_size, bus.aw_burst}, {8'd0, 3'd3, 2'b01});
          check("aw_fixed", {bus.aw_id, bus.aw_lock, bus.aw_cache, bus.aw_prot, bus.aw_qos,
                             bus.aw_region, bus.aw_atop, bus.aw_user}, 64'd0);
        end
      end else begin bus.aw_ready = 0; aw_cnt++; end
      if (!bus.w_valid) begin bus.w_ready = 0; w_cnt = 0; end
      else if (w_cnt >= w_dly) begin
        bus.w_ready = 1; w_cnt = 0; w_seen = 1; w_hs_cyc = cyc;
        if (w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
        else begin
          a = w_q.pop_front();
          check("w_data", bus.w_data, a.wdata);
          check("w_strb_last_user", {bus.w_strb, bus.w_last, bus.w_user}, {a.be, 1'b1, 10'd0});
        end
      end else begin bus.w_ready = 0; w_cnt++; end
      if (aw_seen && w_seen) begin b_pend = 1; b_cnt = 0; aw_seen = 0; w_seen = 0; end
    end
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog: observed no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin : stim
    int waited, gc, n;
    logic wr;
    logic [1:0] rs;
    req = 0; we = 0; addr = '0; be = '0; wdata = '0; rst_i = 1'b1;
    last_rdata = '0; rd_data = '0; r_resp_cfg = 0; b_resp_cfg = 0;
    set_dly(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_rvalid_err_werr", {rvalid, err, write_err}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_valids", {bus.aw_valid, bus.w_valid, bus.ar_valid}, 64'd0);
    check("rst_readies", {bus.b_ready, bus.r_ready}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Zero-wait read of an unaligned address.
    issue(0, 64'h1004, 8'h00, 64'h0, 64'hDEADBEEF_CAFEF00D, 2'b00, 3, waited, gc);
    wait_done(20);

    // Write with AW held off three cycles.
    set_dly(0, 3, 0, 0, 0);
    issue(1, 64'h2000, 8'h0F, 64'h11223344, 64'h0, 2'b00, Posted ? 5 : 6, waited, gc);
    wait_done(30);
    check("wr_w_hs_cycle", 64'(w_hs_cyc - gc), 64'd1);
    check("wr_aw_hs_cycle", 64'(aw_hs_cyc - gc), 64'd4);
    check("rdata_hold_after_write", rdata, 64'hDEADBEEF_CAFEF00D);

    // Read error, then a new request in the completion cycle.
    set_dly(0, 0, 0, 0, 0);
    issue(0, 64'h3000, 8'h00, 64'h0, 64'h0BAD0BAD_0BAD0BAD, 2'b10, 3, waited, gc);
    wait_rvalid(20);
    issue(0, 64'h3008, 8'h00, 64'h0, 64'hA5A5A5A5_5A5A5A5A, 2'b00, 3, waited, gc);
    check("b2b_gnt_wait", 64'(waited), 64'd0);
    wait_done(20);

    // AR backpressure: address phase stable, further requests refused.
    set_dly(10, 0, 0, 0, 0);
    issue(0, 64'h5010, 8'h00, 64'h0, 64'h0F0F0F0F_F0F0F0F0, 2'b00, 13, waited, gc);
    for (int i = 0; i < 8; i++) begin
      req = 1'b1; we = 1'b0; addr = 64'h6000;
      #1;
      check("bp_gnt", {63'd0, gnt}, 64'd0);
      check("bp_ar_valid", {63'd0, bus.ar_valid}, 64'd1);
      check("bp_ar_addr", bus.ar_addr, 64'h5010);
      @(negedge clk);
    end
    req = 1'b0;
    wait_done(30);

    // Erroring write with slow B.
    set_dly(0, 0, 0, 5, 0);
    issue(1, 64'h7000, 8'hFF, 64'hFEEDFACE_01234567, 64'h0, 2'b11, Posted ? 2 : 8, waited, gc);
    wait_rvalid(30);
    issue(0, 64'h7008, 8'h00, 64'h0, 64'h13579BDF_2468ACE0, 2'b00, 3, waited, gc);
    check("posted_gnt_withheld", 64'(waited), Posted ? 64'd6 : 64'd0);
    wait_done(30);
    check("write_err_set", {63'd0, write_err}, {63'd0, Posted});
    set_dly(0, 0, 0, 0, 0);
    issue(0, 64'h7010, 8'h00, 64'h0, 64'h0, 2'b00, 3, waited, gc);
    wait_done(20);
    check("write_err_sticky", {63'd0, write_err}, {63'd0, Posted});

    // Reset while waiting on R.
    set_dly(0, 0, 0, 0, 1000);
    issue(0, 64'h4000, 8'h00, 64'h0, 64'h55555555_55555555, 2'b00, -1, waited, gc);
    n = 0;
    while (!bus.r_ready && n < 20) begin @(negedge clk); n++; end
    check("rst_reached_wait_r", {63'd0, bus.r_ready}, 64'd1);
    rst_i = 1'b1;
    #1;
    check("rst_mid_valids", {bus.aw_valid, bus.w_valid, bus.ar_valid}, 64'd0);
    check("rst_mid_readies", {bus.b_ready, bus.r_ready, rvalid}, 64'd0);
    @(posedge clk);
    #1;
    check("rst_mid_edge", {bus.ar_valid, bus.r_ready, rvalid, write_err}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    sb_q.delete(); ax_q.delete(); w_q.delete();
    last_rdata = '0;
    check("rst_mid_rdata", rdata, 64'd0);
    set_dly(0, 0, 0, 0, 0);
    rst_i = 1'b0;
    @(negedge clk);
    issue(0, 64'h4008, 8'h00, 64'h0, 64'h01234567_89ABCDEF, 2'b00, 3, waited, gc);
    wait_done(20);

    // Mixed traffic with random channel delays.
    for (int k = 0; k < 8; k++) begin
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      rs = (!wr && $urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
      issue(wr, {32'd0, $urandom}, 8'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            rs, -1, waited, gc);
      wait_done(60);
    end
    check("write_err_clear_after_reset", {63'd0, write_err}, 64'd0);
    check("scoreboard_empty", 64'(sb_q.size() + ax_q.size() + w_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
